// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Memory-side end of the byte-serial mode/valid/ready link. Each handshake
//   carries one byte. Bytes are kept in an internal array. A read returns its
//   byte after READ_LATENCY cycles, marked by a one-cycle r_data_valid pulse.
//
// Parameters
//   ADDR_BITS    : the array holds 2**ADDR_BITS bytes
//   READ_LATENCY : cycles from read acceptance to r_data_valid (1..15)
//
// Ports
//   clk          : rising-edge clock
//   rstn         : synchronous active-low reset
//   mode         : 0 = read, 1 = write (qualified by valid)
//   valid        : request from the initiator, held until accepted
//   ready        : registered acceptance strobe; a transfer is valid && ready
//   addr         : 64-bit byte address
//   w_data       : write byte
//   r_data_valid : one-cycle pulse while r_data carries a read result
//   r_data       : read byte, holds the last returned value between pulses
//   oob_err      : one-cycle pulse in the cycle after an out-of-range acceptance
module main_memory_responder #(
  parameter int unsigned ADDR_BITS    = 12,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mode,
  input  logic        valid,
  output logic        ready,
  input  logic [63:0] addr,
  input  logic [7:0]  w_data,
  output logic        r_data_valid,
  output logic [7:0]  r_data,
  output logic        oob_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int unsigned DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

  state_t                 state;
  logic [3:0]             cnt;
  logic [7:0]             data_q;
  logic [7:0]             mem [DEPTH];

  logic [ADDR_BITS-1:0]   idx;
  logic                   oob_addr;
  logic [7:0]             rd_byte;
  logic                   wr_en;

  assign idx      = addr[ADDR_BITS-1:0];
  assign oob_addr = (addr[63:ADDR_BITS] != '0);
  // Out-of-range reads return zero instead of an aliased array entry.
  assign rd_byte  = oob_addr ? '0 : mem[idx];
  // Writes only happen on a real transfer, never while reset is asserted.
  assign wr_en    = rstn && (state == ACCEPT) && valid && mode && !oob_addr;

  // The array is deliberately not reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      ready        <= 1'b0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      oob_err      <= 1'b0;
      cnt          <= '0;
      data_q       <= '0;
    end else begin
      ready        <= 1'b0;
      r_data_valid <= 1'b0;
      oob_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            state <= ACCEPT;
            ready <= 1'b1;
          end
        end
        ACCEPT: begin
          state <= IDLE;
          if (valid) begin
            oob_err <= oob_addr;
            if (!mode) begin
              data_q <= rd_byte;
              cnt    <= LAT_LOAD;
              // With unit latency the response is issued directly from the
              // array read, since data_q is only loaded at this same edge.
              if (READ_LATENCY == 1) begin
                state        <= RESP;
                r_data_valid <= 1'b1;
                r_data       <= rd_byte;
              end else begin
                state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state        <= RESP;
            r_data_valid <= 1'b1;
            r_data       <= data_q;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        valid  [3];
  logic        mode   [3];
  logic [63:0] addr   [3];
  logic [7:0]  w_data [3];
  logic        ready  [3];
  logic        rdv    [3];
  logic [7:0]  r_data [3];
  logic        oob    [3];

  int lat [3] = '{2, 1, 5};

  main_memory_responder #(.ADDR_BITS(12), .READ_LATENCY(2)) u_lat2 (
    .clk(clk), .rstn(rstn), .mode(mode[0]), .valid(valid[0]), .ready(ready[0]),
    .addr(addr[0]), .w_data(w_data[0]), .r_data_valid(rdv[0]), .r_data(r_data[0]),
    .oob_err(oob[0]));

  main_memory_responder #(.ADDR_BITS(12), .READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .mode(mode[1]), .valid(valid[1]), .ready(ready[1]),
    .addr(addr[1]), .w_data(w_data[1]), .r_data_valid(rdv[1]), .r_data(r_data[1]),
    .oob_err(oob[1]));

  main_memory_responder #(.ADDR_BITS(12), .READ_LATENCY(5)) u_lat5 (
    .clk(clk), .rstn(rstn), .mode(mode[2]), .valid(valid[2]), .ready(ready[2]),
    .addr(addr[2]), .w_data(w_data[2]), .r_data_valid(rdv[2]), .r_data(r_data[2]),
    .oob_err(oob[2]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard state and reference memory, one set per instance.
  int         due_q [3][$];
  logic [7:0] dat_q [3][$];
  int         oob_q [3][$];
  logic [7:0] model [3][4096];
  int         last_resp [3] = '{-100, -100, -100};
  int         rdv_cnt   [3] = '{0, 0, 0};
  logic       prev_rdv  [3] = '{1'b0, 1'b0, 1'b0};
  logic       prev_ready[3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // Monitor: pops expectations whenever an instance presents a response.
  int         mon_d;
  logic [7:0] mon_e;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdv[i] === 1'b1) begin
        rdv_cnt[i]++;
        check($sformatf("rdv_width[%0d]", i), prev_rdv[i], 0);
        if (due_q[i].size() == 0) begin
          fail_now($sformatf("unexpected_rdv[%0d]", i));
        end else begin
          mon_d = due_q[i].pop_front();
          mon_e = dat_q[i].pop_front();
          check($sformatf("rd_cycle[%0d]", i), cyc, mon_d);
          check($sformatf("rd_data[%0d]", i), r_data[i], mon_e);
        end
        last_resp[i] = cyc;
      end else if (due_q[i].size() > 0 && due_q[i][0] < cyc) begin
        fail_now($sformatf("missing_rdv[%0d]", i));
        mon_d = due_q[i].pop_front();
        mon_e = dat_q[i].pop_front();
      end
      if (oob[i] === 1'b1) begin
        if (oob_q[i].size() == 0) fail_now($sformatf("unexpected_oob[%0d]", i));
        else check($sformatf("oob_cycle[%0d]", i), cyc, oob_q[i].pop_front());
      end else if (oob_q[i].size() > 0 && oob_q[i][0] < cyc) begin
        fail_now($sformatf("missing_oob[%0d]", i));
        mon_d = oob_q[i].pop_front();
      end
      if (ready[i] === 1'b1) begin
        check($sformatf("ready_consec[%0d]", i), prev_ready[i], 0);
        check($sformatf("ready_busy[%0d]", i), due_q[i].size(), 0);
        check($sformatf("ready_after_resp[%0d]", i), (cyc - last_resp[i]) >= 2, 1);
      end
      prev_rdv[i]   = rdv[i];
      prev_ready[i] = ready[i];
    end
  end

  // Issue one transaction and wait (bounded) for its acceptance. Inputs stay
  // driven past the transfer edge; valid is left high for the caller.
  task automatic txn(input int i, input bit m, input logic [63:0] a,
                     input logic [7:0] d, output int acc, output int w);
    int  start;
    bit  is_oob;
    start     = cyc;
    valid[i]  = 1'b1;
    mode[i]   = m;
    addr[i]   = a;
    w_data[i] = d;
    acc       = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ready[i] === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      fail_now($sformatf("accept_timeout[%0d]", i));
      valid[i] = 1'b0;
      w = -1;
      return;
    end
    w = acc - start;
    #1;
    is_oob = (a >> 12) != 64'd0;
    if (is_oob) oob_q[i].push_back(acc + 1);
    if (m) begin
      if (!is_oob) model[i][a[11:0]] = d;
    end else begin
      due_q[i].push_back(acc + lat[i]);
      dat_q[i].push_back(is_oob ? 8'h00 : model[i][a[11:0]]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i, input int n);
    valid[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [63:0] pool [9];

  initial begin
    int acc, w, prev_acc, saved, k;
    logic [63:0] a;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b1; mode[i] = 1'b1; addr[i] = 64'h0; w_data[i] = 8'h3C;
    end
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("rst_ready[%0d]", i), ready[i], 0);
        check($sformatf("rst_rdv[%0d]", i), rdv[i], 0);
        check($sformatf("rst_oob[%0d]", i), oob[i], 0);
        check($sformatf("rst_rdata[%0d]", i), r_data[i], 8'h00);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("first_ready[%0d]", i), ready[i], 1);
      model[i][0] = 8'h3C;
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Write then read.
    txn(0, 1'b1, 64'h10, 8'hA5, acc, w);
    check("wr_ready_delay", w, 1);
    txn(0, 1'b0, 64'h10, 8'h00, acc, w);
    check("rd_ready_delay", w, 1);
    idle(0, 6);
    check("rdata_hold", r_data[0], 8'hA5);

    // Byte sweep with valid held continuously.
    @(posedge clk); #1;
    prev_acc = 0;
    for (int j = 0; j < 8; j++) begin
      txn(0, 1'b1, 64'h100 + 64'(j), 8'(8'h11 * (j + 1)), acc, w);
      if (j > 0) check("sweep_wr_spacing", acc - prev_acc, 2);
      prev_acc = acc;
    end
    for (int j = 0; j < 8; j++) txn(0, 1'b0, 64'h100 + 64'(j), 8'h00, acc, w);
    idle(0, 8);

    // Out-of-range handling and aliasing.
    @(posedge clk); #1;
    txn(0, 1'b1, 64'h1_0000_0000, 8'hFF, acc, w);
    txn(0, 1'b0, 64'h1_0000_0000, 8'h00, acc, w);
    txn(0, 1'b0, 64'h0, 8'h00, acc, w);
    idle(0, 8);

    // Latency variants.
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      txn(i, 1'b1, 64'h20, 8'h5A, acc, w);
      txn(i, 1'b0, 64'h20, 8'h00, acc, w);
      txn(i, 1'b0, 64'hFFF, 8'h00, acc, w);
      txn(i, 1'b0, 64'h0, 8'h00, acc, w);
      idle(i, 10);
    end

    // Reset while a read is pending.
    @(posedge clk); #1;
    txn(0, 1'b1, 64'h30, 8'h77, acc, w);
    txn(0, 1'b0, 64'h30, 8'h00, acc, w);
    valid[0] = 1'b0;
    rstn = 1'b0;
    due_q[0].delete();
    dat_q[0].delete();
    saved = rdv_cnt[0];
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    check("no_rdv_after_reset", rdv_cnt[0], saved);
    @(posedge clk); #1;
    txn(0, 1'b0, 64'h30, 8'h00, acc, w);
    check("post_reset_ready_delay", w, 1);
    idle(0, 6);

    // Randomized traffic on every instance.
    for (int j = 0; j < 8; j++) pool[j] = 64'h200 + 64'(j);
    pool[8] = 64'hFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 9; j++) txn(i, 1'b1, pool[j], 8'($urandom), acc, w);
      for (int n = 0; n < 40; n++) begin
        k = int'($urandom_range(0, 9));
        if (k == 9) a = 64'h1 << (12 + $urandom_range(0, 51));
        else a = pool[k];
        txn(i, 1'($urandom), a, 8'($urandom), acc, w);
        if ($urandom_range(0, 2) == 0) begin
          idle(i, int'($urandom_range(1, 4)));
        end
      end
      idle(i, 10);
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rd_q_empty[%0d]", i), due_q[i].size(), 0);
      check($sformatf("oob_q_empty[%0d]", i), oob_q[i].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
